// File: rtl/rot_lut_arbiter_if.sv
// Request, response and ROM-side signals shared between the rotation LUT
// arbiter and its two requesters / the rotation ROM.
interface rot_lut_arbiter_if #(
    parameter int ADDR_W = 11
);
    logic [ADDR_W-1:0] req0_addr;
    logic [ADDR_W-1:0] req1_addr;
    logic              req0_stb;
    logic              req1_stb;
    logic              req0_full;
    logic              req1_full;
    logic [31:0]       resp0_data;
    logic [31:0]       resp1_data;
    logic              resp0_stb;
    logic              resp1_stb;
    logic [ADDR_W-1:0] lut_addr;
    logic [31:0]       lut_data;

    modport master (
        output req0_addr, req1_addr, req0_stb, req1_stb, lut_data,
        input  req0_full, req1_full, resp0_data, resp1_data,
        input  resp0_stb, resp1_stb, lut_addr
    );

    modport slave (
        input  req0_addr, req1_addr, req0_stb, req1_stb, lut_data,
        output req0_full, req1_full, resp0_data, resp1_data,
        output resp0_stb, resp1_stb, lut_addr
    );
endinterface

// File: rtl/rot_lut_arbiter.sv
// Shares one rotation ROM between two requesters: per-requester address
// queues, round-robin or fixed-priority grant, and tagged response return.
module rot_lut_arbiter #(
    parameter int         ADDR_W     = 11,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] SR_ADDR    = 8'd20
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    output logic [1:0]       ovf,
    rot_lut_arbiter_if.slave bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    logic [ADDR_W-1:0] mem_q [2][FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q [2];
    logic [PTR_W-1:0]  wr_ptr_d [2];
    logic [PTR_W-1:0]  rd_ptr_q [2];
    logic [PTR_W-1:0]  rd_ptr_d [2];
    logic [CNT_W-1:0]  cnt_q [2];
    logic [CNT_W-1:0]  cnt_d [2];
    logic [31:0]       resp_data_q [2];
    logic [31:0]       resp_data_d [2];
    logic [1:0]        full_q, full_d, ovf_q, ovf_d, resp_stb_q, resp_stb_d;
    logic              mode_q, mode_d, last_q, last_d;
    logic [ADDR_W-1:0] lut_addr_q, lut_addr_d;
    logic              tag1_vld_q, tag1_id_q, tag2_vld_q, tag2_id_q;

    logic [ADDR_W-1:0] req_addr_s [2];
    logic [1:0]        req_stb_s, push_s, pop_s, drop_s, nonempty_s;
    logic              gnt_vld_s, gnt_id_s, sr_hit_s, unused_set_s;

    assign req_addr_s[0] = bus.req0_addr;
    assign req_addr_s[1] = bus.req1_addr;
    assign req_stb_s     = {bus.req1_stb, bus.req0_stb};
    assign unused_set_s  = ^set_data[31:2];

    // Full is registered, so a pop in the same cycle never frees room for a push.
    assign push_s     = req_stb_s & {2{enable}} & ~full_q;
    assign drop_s     = req_stb_s & {2{enable}} & full_q;
    assign pop_s      = {gnt_vld_s & gnt_id_s, gnt_vld_s & ~gnt_id_s};
    assign nonempty_s = {cnt_q[1] != '0, cnt_q[0] != '0};
    assign sr_hit_s   = set_stb && (set_addr == SR_ADDR);

    // Grant selection: single contender wins; ties go by mode and last grant.
    always_comb begin
        gnt_vld_s = 1'b0;
        gnt_id_s  = 1'b0;
        if (enable) begin
            case (nonempty_s)
                2'b01: begin
                    gnt_vld_s = 1'b1;
                    gnt_id_s  = 1'b0;
                end
                2'b10: begin
                    gnt_vld_s = 1'b1;
                    gnt_id_s  = 1'b1;
                end
                2'b11: begin
                    gnt_vld_s = 1'b1;
                    gnt_id_s  = mode_q ? 1'b0 : ~last_q;
                end
                default: begin
                    gnt_vld_s = 1'b0;
                    gnt_id_s  = 1'b0;
                end
            endcase
        end else begin
            gnt_vld_s = 1'b0;
            gnt_id_s  = 1'b0;
        end
    end

    // Next-state for queues, settings, issue register and response stage.
    always_comb begin
        for (int n = 0; n < 2; n++) begin
            wr_ptr_d[n] = push_s[n] ? wr_ptr_q[n] + PTR_ONE : wr_ptr_q[n];
            rd_ptr_d[n] = pop_s[n] ? rd_ptr_q[n] + PTR_ONE : rd_ptr_q[n];
            case ({push_s[n], pop_s[n]})
                2'b10:   cnt_d[n] = cnt_q[n] + CNT_ONE;
                2'b01:   cnt_d[n] = cnt_q[n] - CNT_ONE;
                default: cnt_d[n] = cnt_q[n];
            endcase
            full_d[n] = (cnt_d[n] == CNT_FULL);
        end
        if (gnt_vld_s) begin
            lut_addr_d = mem_q[gnt_id_s][rd_ptr_q[gnt_id_s]];
            last_d     = gnt_id_s;
        end else begin
            lut_addr_d = lut_addr_q;
            last_d     = last_q;
        end
        // A fresh overflow is OR-ed in after the clear so it is never lost.
        ovf_d  = ((sr_hit_s && set_data[1]) ? 2'b00 : ovf_q) | drop_s;
        mode_d = sr_hit_s ? set_data[0] : mode_q;
        resp_stb_d = {tag2_vld_q & tag2_id_q, tag2_vld_q & ~tag2_id_q};
        for (int n = 0; n < 2; n++) begin
            resp_data_d[n] = resp_stb_d[n] ? bus.lut_data : resp_data_q[n];
        end
    end

    // State registers; the tag pipeline tracks the one-cycle ROM latency.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int n = 0; n < 2; n++) begin
                for (int k = 0; k < FIFO_DEPTH; k++) begin
                    mem_q[n][k] <= '0;
                end
                wr_ptr_q[n]    <= '0;
                rd_ptr_q[n]    <= '0;
                cnt_q[n]       <= '0;
                resp_data_q[n] <= 32'h0000_0000;
            end
            full_q     <= 2'b00;
            ovf_q      <= 2'b00;
            resp_stb_q <= 2'b00;
            mode_q     <= 1'b0;
            last_q     <= 1'b1;
            lut_addr_q <= '0;
            tag1_vld_q <= 1'b0;
            tag1_id_q  <= 1'b0;
            tag2_vld_q <= 1'b0;
            tag2_id_q  <= 1'b0;
        end else begin
            for (int n = 0; n < 2; n++) begin
                if (push_s[n]) begin
                    mem_q[n][wr_ptr_q[n]] <= req_addr_s[n];
                end
                wr_ptr_q[n]    <= wr_ptr_d[n];
                rd_ptr_q[n]    <= rd_ptr_d[n];
                cnt_q[n]       <= cnt_d[n];
                resp_data_q[n] <= resp_data_d[n];
            end
            full_q     <= full_d;
            ovf_q      <= ovf_d;
            resp_stb_q <= resp_stb_d;
            mode_q     <= mode_d;
            last_q     <= last_d;
            lut_addr_q <= lut_addr_d;
            tag1_vld_q <= gnt_vld_s;
            tag1_id_q  <= gnt_id_s;
            tag2_vld_q <= tag1_vld_q;
            tag2_id_q  <= tag1_id_q;
        end
    end

    assign bus.req0_full  = full_q[0];
    assign bus.req1_full  = full_q[1];
    assign bus.resp0_data = resp_data_q[0];
    assign bus.resp1_data = resp_data_q[1];
    assign bus.resp0_stb  = resp_stb_q[0];
    assign bus.resp1_stb  = resp_stb_q[1];
    assign bus.lut_addr   = lut_addr_q;
    assign ovf            = ovf_q;
endmodule

// File: tb/tb_rot_lut_arbiter.sv
// Scoreboard bench for rot_lut_arbiter: a queue-level model predicts grants,
// flags and per-requester response data; a monitor checks every response.
`timescale 1ns/1ps
module tb_rot_lut_arbiter;
    localparam int         AW    = 11;
    localparam int         DEPTH = 4;
    localparam logic [7:0] SR    = 8'd20;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        set_stb;
    logic [7:0]  set_addr;
    logic [31:0] set_data;
    logic [1:0]  ovf;

    rot_lut_arbiter_if #(.ADDR_W(AW)) bus ();

    rot_lut_arbiter #(.ADDR_W(AW), .FIFO_DEPTH(DEPTH), .SR_ADDR(SR)) dut (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .set_stb  (set_stb),
        .set_addr (set_addr),
        .set_data (set_data),
        .ovf      (ovf),
        .bus      (bus.slave)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [AW-1:0] mq0[$], mq1[$];
    logic [31:0]   exp0[$], exp1[$];
    logic [AW-1:0] lut_m;
    logic [1:0]    ovf_m;
    bit            mode_m, last_m;
    logic [AW-1:0] seen[$];

    function automatic logic [31:0] rom(input logic [AW-1:0] a);
        if (a == 11'h005) rom = 32'h1234_5678;
        else              rom = {5'd0, a, 16'h0000} ^ (32'h9E37_79B9 * 32'(a));
    endfunction

    // ROM stub: data valid one cycle after the address
    always @(posedge clock) bus.lut_data <= rom(bus.lut_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // response monitor: pops the per-requester expectation queue
    always @(negedge clock) begin
        if (reset === 1'b1) begin
            if (bus.resp0_stb === 1'b1) begin
                if (exp0.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp0_spurious: got data %h want no response", bus.resp0_data);
                end else chk("resp0_data", bus.resp0_data, exp0.pop_front());
            end
            if (bus.resp1_stb === 1'b1) begin
                if (exp1.size() == 0) begin
                    total++; bad++;
                    $display("FAIL resp1_spurious: got data %h want no response", bus.resp1_data);
                end else chk("resp1_data", bus.resp1_data, exp1.pop_front());
            end
        end
    end

    task automatic step(input bit en, input bit s0, input logic [AW-1:0] a0,
                        input bit s1, input logic [AW-1:0] a1,
                        input bit sw, input logic [7:0] sa, input logic [31:0] sd);
        int gid;
        bit f0, f1, d0, d1, hit;
        @(negedge clock);
        chk("lut_addr", 32'(bus.lut_addr), 32'(lut_m));
        chk("ovf", 32'(ovf), 32'(ovf_m));
        chk("full", 32'({bus.req1_full, bus.req0_full}),
            32'({mq1.size() == DEPTH, mq0.size() == DEPTH}));
        enable = en; bus.req0_stb = s0; bus.req0_addr = a0;
        bus.req1_stb = s1; bus.req1_addr = a1;
        set_stb = sw; set_addr = sa; set_data = sd;
        f0 = (mq0.size() == DEPTH);
        f1 = (mq1.size() == DEPTH);
        gid = -1;
        if (en) begin
            if (mq0.size() > 0 && mq1.size() > 0) gid = (mode_m || last_m) ? 0 : 1;
            else if (mq0.size() > 0) gid = 0;
            else if (mq1.size() > 0) gid = 1;
        end
        if (gid == 0) begin lut_m = mq0.pop_front(); last_m = 1'b0; end
        else if (gid == 1) begin lut_m = mq1.pop_front(); last_m = 1'b1; end
        d0 = en && s0 && f0;
        d1 = en && s1 && f1;
        if (en && s0 && !f0) begin mq0.push_back(a0); exp0.push_back(rom(a0)); end
        if (en && s1 && !f1) begin mq1.push_back(a1); exp1.push_back(rom(a1)); end
        hit = sw && (sa == SR);
        if (hit && sd[1]) ovf_m = 2'b00;
        ovf_m = ovf_m | {d1, d0};
        if (hit) mode_m = sd[0];
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0, 8'd0, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        #1;
        reset = 1'b0;
        enable = 1'b0; bus.req0_stb = 1'b0; bus.req1_stb = 1'b0; set_stb = 1'b0;
        mq0.delete(); mq1.delete(); exp0.delete(); exp1.delete();
        lut_m = '0; ovf_m = 2'b00; mode_m = 1'b0; last_m = 1'b1;
        #1;
        chk("rst_flags", 32'({bus.resp1_stb, bus.resp0_stb, bus.req1_full, bus.req0_full, ovf}), 32'd0);
        chk("rst_data", bus.resp0_data | bus.resp1_data, 32'd0);
        chk("rst_lut_addr", 32'(bus.lut_addr), 32'd0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1 reset = 1'b1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; set_stb = 1'b0; set_addr = 8'd0; set_data = 32'd0;
        bus.req0_stb = 1'b0; bus.req1_stb = 1'b0; bus.req0_addr = '0; bus.req1_addr = '0;
        do_reset();

        // single request: latency and data
        step(1'b1, 1'b1, 11'h005, 1'b0, '0, 1'b0, 8'd0, 32'd0);
        idle(2);
        chk("t1_lut_addr", 32'(bus.lut_addr), 32'h005);
        idle(1);
        chk("t1_resp_early", 32'({bus.resp1_stb, bus.resp0_stb}), 32'd0);
        idle(1);
        chk("t1_resp_stb", 32'({bus.resp1_stb, bus.resp0_stb}), 32'b01);
        chk("t1_resp_data", bus.resp0_data, 32'h1234_5678);
        idle(4);

        // round-robin tie
        do_reset();
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            if (i < 4) step(1'b1, 1'b1, AW'(32'h100 + i), 1'b1, AW'(32'h200 + i), 1'b0, 8'd0, 32'd0);
            else idle(1);
            seen.push_back(bus.lut_addr);
        end
        for (int k = 0; k < 8; k++)
            chk("t2_rr_order", 32'(seen[k+2]), (k % 2 == 0) ? 32'h100 + k/2 : 32'h200 + k/2);
        idle(4);

        // fixed priority
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, SR, 32'h1);
        seen.delete();
        for (int i = 0; i < 10; i++) begin
            if (i < 4) step(1'b1, 1'b1, AW'(32'h300 + i), 1'b1, AW'(32'h380 + i), 1'b0, 8'd0, 32'd0);
            else idle(1);
            seen.push_back(bus.lut_addr);
        end
        for (int k = 0; k < 8; k++)
            chk("t3_prio_order", 32'(seen[k+2]), (k < 4) ? 32'h300 + k : 32'h380 + k - 4);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, SR, 32'h0);
        idle(6);

        // overflow, clear, and stb ignored while disabled
        for (int i = 0; i < 14; i++)
            step(1'b1, 1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b0, 8'd0, 32'd0);
        idle(12);
        chk("t4_ovf_seen", 32'(ovf != 2'b00), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0, '0, 1'b1, SR, 32'h2);
        idle(1);
        chk("t4_ovf_clear", 32'(ovf), 32'd0);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, AW'(i), 1'b1, AW'(i), 1'b0, 8'd0, 32'd0);
        chk("t4_dis_ovf", 32'(ovf), 32'd0);
        chk("t4_dis_full", 32'({bus.req1_full, bus.req0_full}), 32'd0);
        idle(6);

        // enable drop after a grant
        step(1'b1, 1'b1, 11'h040, 1'b0, '0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 1'b1, 11'h041, 1'b0, '0, 1'b0, 8'd0, 32'd0);
        step(1'b1, 1'b1, 11'h042, 1'b0, '0, 1'b0, 8'd0, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 11'h7FF, 1'b0, '0, 1'b0, 8'd0, 32'd0);
        chk("t5_lut_hold", 32'(bus.lut_addr), 32'h041);
        idle(8);

        // reset with requests queued and in flight
        for (int i = 0; i < 5; i++)
            step(1'b1, 1'b1, AW'($urandom), 1'b1, AW'($urandom), 1'b0, 8'd0, 32'd0);
        do_reset();
        idle(8);

        // randomized traffic
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 7) != 0, $urandom_range(0, 9) < 6, AW'($urandom),
                 $urandom_range(0, 9) < 6, AW'($urandom), $urandom_range(0, 29) == 0,
                 ($urandom_range(0, 1) == 1) ? SR : 8'd21, 32'($urandom_range(0, 3)));
        idle(16);
        chk("drain0", 32'(exp0.size()), 32'd0);
        chk("drain1", 32'(exp1.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
